// File: rtl/freq_min_finder.sv
// Scans the symbol-count table in SRAM after counting finishes and reports the two
// least-frequent non-zero symbols plus the number of non-zero symbols.
module freq_min_finder #(
    parameter int NUM_SYM   = 256,
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_start,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_r,
    input  logic [CNT_W-1:0]  scan_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        min1_sym,
    output logic [CNT_W-1:0]  min1_cnt,
    output logic [7:0]        min2_sym,
    output logic [CNT_W-1:0]  min2_cnt,
    output logic [8:0]        nz_count,
    output logic              err
);

    localparam int IDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  scan_addr_q, scan_addr_d;
    logic               scan_r_q, scan_r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Read-issued flag and symbol index, delayed to line up with scan_data.
    logic               rd_v_q, rd_v_d;
    logic [IDX_W-1:0]   rd_sym_q, rd_sym_d;

    logic               min1_v_q, min1_v_d;
    logic [7:0]         min1_sym_q, min1_sym_d;
    logic [CNT_W-1:0]   min1_cnt_q, min1_cnt_d;
    logic               min2_v_q, min2_v_d;
    logic [7:0]         min2_sym_q, min2_sym_d;
    logic [CNT_W-1:0]   min2_cnt_q, min2_cnt_d;
    logic [8:0]         nz_q, nz_d;

    // Result values after folding in the word returned this cycle.
    logic               upd_min1_v_s;
    logic [7:0]         upd_min1_sym_s;
    logic [CNT_W-1:0]   upd_min1_cnt_s;
    logic               upd_min2_v_s;
    logic [7:0]         upd_min2_sym_s;
    logic [CNT_W-1:0]   upd_min2_cnt_s;
    logic [8:0]         upd_nz_s;
    logic [7:0]         cur_sym_s;

    assign cur_sym_s = 8'(rd_sym_q);

    // Compare the returned count against the two running minima (strict less-than keeps the lower index on ties).
    always_comb begin
        upd_min1_v_s   = min1_v_q;
        upd_min1_sym_s = min1_sym_q;
        upd_min1_cnt_s = min1_cnt_q;
        upd_min2_v_s   = min2_v_q;
        upd_min2_sym_s = min2_sym_q;
        upd_min2_cnt_s = min2_cnt_q;
        upd_nz_s       = nz_q;
        if (rd_v_q && (scan_data != {CNT_W{1'b0}})) begin
            upd_nz_s = nz_q + 9'd1;
            if (!min1_v_q || (scan_data < min1_cnt_q)) begin
                upd_min2_v_s   = min1_v_q;
                upd_min2_sym_s = min1_sym_q;
                upd_min2_cnt_s = min1_cnt_q;
                upd_min1_v_s   = 1'b1;
                upd_min1_sym_s = cur_sym_s;
                upd_min1_cnt_s = scan_data;
            end else if (!min2_v_q || (scan_data < min2_cnt_q)) begin
                upd_min2_v_s   = 1'b1;
                upd_min2_sym_s = cur_sym_s;
                upd_min2_cnt_s = scan_data;
            end else begin
                upd_min2_v_s   = min2_v_q;
            end
        end else begin
            upd_nz_s = nz_q;
        end
    end

    // Scan sequencing: next state, address generation and result register inputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scan_addr_d = scan_addr_q;
        scan_r_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rd_v_d      = scan_r_q;
        rd_sym_d    = idx_q;
        min1_v_d    = upd_min1_v_s;
        min1_sym_d  = upd_min1_sym_s;
        min1_cnt_d  = upd_min1_cnt_s;
        min2_v_d    = upd_min2_v_s;
        min2_sym_d  = upd_min2_sym_s;
        min2_cnt_d  = upd_min2_cnt_s;
        nz_d        = upd_nz_s;

        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    state_d     = ST_SCAN;
                    idx_d       = {IDX_W{1'b0}};
                    scan_addr_d = ADDR_W'(BASE_ADDR);
                    scan_r_d    = 1'b1;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    min1_v_d    = 1'b0;
                    min1_sym_d  = 8'd0;
                    min1_cnt_d  = {CNT_W{1'b0}};
                    min2_v_d    = 1'b0;
                    min2_sym_d  = 8'd0;
                    min2_cnt_d  = {CNT_W{1'b0}};
                    nz_d        = 9'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_DRAIN;
                    scan_r_d = 1'b0;
                end else begin
                    idx_d       = idx_q + IDX_W'(1'b1);
                    scan_addr_d = scan_addr_q + ADDR_W'(1'b1);
                    scan_r_d    = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last word is folded in on this edge, so err must see the updated count.
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = (upd_nz_s < 9'd2);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                scan_r_d = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            scan_addr_q <= {ADDR_W{1'b0}};
            scan_r_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_v_q      <= 1'b0;
            rd_sym_q    <= {IDX_W{1'b0}};
            min1_v_q    <= 1'b0;
            min1_sym_q  <= 8'd0;
            min1_cnt_q  <= {CNT_W{1'b0}};
            min2_v_q    <= 1'b0;
            min2_sym_q  <= 8'd0;
            min2_cnt_q  <= {CNT_W{1'b0}};
            nz_q        <= 9'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_addr_q <= scan_addr_d;
            scan_r_q    <= scan_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_v_q      <= rd_v_d;
            rd_sym_q    <= rd_sym_d;
            min1_v_q    <= min1_v_d;
            min1_sym_q  <= min1_sym_d;
            min1_cnt_q  <= min1_cnt_d;
            min2_v_q    <= min2_v_d;
            min2_sym_q  <= min2_sym_d;
            min2_cnt_q  <= min2_cnt_d;
            nz_q        <= nz_d;
        end
    end

    assign scan_addr = scan_addr_q;
    assign scan_r    = scan_r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign min1_sym  = min1_sym_q;
    assign min1_cnt  = min1_cnt_q;
    assign min2_sym  = min2_sym_q;
    assign min2_cnt  = min2_cnt_q;
    assign nz_count  = nz_q;

endmodule

// File: tb/tb_freq_min_finder.sv
// Self-checking bench for freq_min_finder: SRAM model, directed and random tables,
// reference results derived by sorting (count, symbol) keys.
module tb_freq_min_finder;

    localparam int NUM_SYM   = 256;
    localparam int ADDR_W    = 10;
    localparam int CNT_W     = 8;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_start;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_r;
    logic [CNT_W-1:0]  scan_data = 8'd0;
    logic              busy;
    logic              done;
    logic [7:0]        min1_sym;
    logic [CNT_W-1:0]  min1_cnt;
    logic [7:0]        min2_sym;
    logic [CNT_W-1:0]  min2_cnt;
    logic [8:0]        nz_count;
    logic              err;

    logic [7:0] mem [0:NUM_SYM-1];

    int n_checks = 0;
    int n_pass   = 0;
    int e_m1s, e_m1c, e_m2s, e_m2c, e_nz, e_err;

    freq_min_finder #(
        .NUM_SYM(NUM_SYM), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .scan_start(scan_start), .scan_addr(scan_addr),
        .scan_r(scan_r), .scan_data(scan_data), .busy(busy), .done(done),
        .min1_sym(min1_sym), .min1_cnt(min1_cnt), .min2_sym(min2_sym),
        .min2_cnt(min2_cnt), .nz_count(nz_count), .err(err)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM read port
    always @(posedge clk) begin
        if (scan_r) scan_data <= mem[8'(scan_addr - ADDR_W'(BASE_ADDR))];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Reference: sort non-zero entries by (count, symbol); the first two are the minima.
    function automatic void ref_model();
        int keys[$];
        keys = {};
        for (int s = 0; s < NUM_SYM; s++)
            if (mem[s] != 8'd0) keys.push_back(int'(mem[s]) * 256 + s);
        keys.sort();
        e_nz = keys.size();
        e_m1s = 0; e_m1c = 0; e_m2s = 0; e_m2c = 0;
        if (e_nz >= 1) begin e_m1c = keys[0] / 256; e_m1s = keys[0] % 256; end
        if (e_nz >= 2) begin e_m2c = keys[1] / 256; e_m2s = keys[1] % 256; end
        e_err = (e_nz < 2) ? 1 : 0;
    endfunction

    task automatic clear_mem();
        for (int s = 0; s < NUM_SYM; s++) mem[s] = 8'd0;
    endtask

    task automatic check_zero(input string name);
        check_eq({name, "/scan_r"},   32'(scan_r),   32'd0);
        check_eq({name, "/busy"},     32'(busy),     32'd0);
        check_eq({name, "/done"},     32'(done),     32'd0);
        check_eq({name, "/scan_addr"},32'(scan_addr),32'd0);
        check_eq({name, "/min1"},     {16'd0, min1_sym, min1_cnt}, 32'd0);
        check_eq({name, "/min2"},     {16'd0, min2_sym, min2_cnt}, 32'd0);
        check_eq({name, "/nz_err"},   {22'd0, nz_count, err}, 32'd0);
    endtask

    // Runs one full scan of the current table; optionally re-pulses scan_start mid-scan.
    task automatic run_scan(input string name, input int start_again_at);
        int nr = 0, nbusy = 0, ndone = 0, done_cyc = 0, addr_bad = 0;
        ref_model();
        @(negedge clk); scan_start = 1'b1;
        @(negedge clk); scan_start = 1'b0;
        for (int cyc = 1; cyc <= 262; cyc++) begin
            if (scan_r) begin
                nr++;
                if (scan_addr !== ADDR_W'(BASE_ADDR + nr - 1) || cyc != nr) addr_bad++;
            end
            if (busy) nbusy++;
            if (done) begin ndone++; done_cyc = cyc; end
            scan_start = (cyc == start_again_at);
            @(negedge clk);
        end
        scan_start = 1'b0;
        check_eq({name, "/scan_r_cycles"}, 32'(nr), 32'(NUM_SYM));
        check_eq({name, "/addr_seq_errs"}, 32'(addr_bad), 32'd0);
        check_eq({name, "/busy_cycles"}, 32'(nbusy), 32'(NUM_SYM + 1));
        check_eq({name, "/done_pulses"}, 32'(ndone), 32'd1);
        check_eq({name, "/done_cycle"}, 32'(done_cyc), 32'(NUM_SYM + 2));
        check_eq({name, "/min1_sym"}, 32'(min1_sym), 32'(e_m1s));
        check_eq({name, "/min1_cnt"}, 32'(min1_cnt), 32'(e_m1c));
        check_eq({name, "/min2_sym"}, 32'(min2_sym), 32'(e_m2s));
        check_eq({name, "/min2_cnt"}, 32'(min2_cnt), 32'(e_m2c));
        check_eq({name, "/nz_count"}, 32'(nz_count), 32'(e_nz));
        check_eq({name, "/err"}, 32'(err), 32'(e_err));
    endtask

    task automatic load_basic();
        clear_mem();
        mem[8'h41] = 8'd5; mem[8'h42] = 8'd3; mem[8'h43] = 8'd9;
    endtask

    initial begin
        int nd, nr;
        rst = 1'b1;
        scan_start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        load_basic();
        run_scan("basic", 0);

        clear_mem();
        mem[8'h10] = 8'd2; mem[8'h20] = 8'd2; mem[8'h30] = 8'd2;
        run_scan("tie", 0);

        clear_mem();
        mem[8'h7F] = 8'd1;
        run_scan("single", 0);

        clear_mem();
        run_scan("all_zero", 0);

        for (int s = 0; s < NUM_SYM; s++) mem[s] = 8'd255;
        mem[8'hFF] = 8'd254;
        run_scan("all_full", 0);

        load_basic();
        run_scan("restart_ignored", 50);

        // Reset at cycle 100 of a scan aborts it without a done pulse
        @(negedge clk); scan_start = 1'b1;
        @(negedge clk); scan_start = 1'b0;
        for (int cyc = 1; cyc < 100; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_zero("rst_abort");
        nd = 0; nr = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) nd++;
            if (scan_r) nr++;
            @(negedge clk);
        end
        check_eq("rst_abort/no_done", 32'(nd), 32'd0);
        check_eq("rst_abort/no_reads", 32'(nr), 32'd0);
        run_scan("after_rst", 0);

        // scan_start coinciding with reset is dropped
        rst = 1'b1; scan_start = 1'b1;
        @(negedge clk); rst = 1'b0; scan_start = 1'b0;
        nr = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (scan_r || busy) nr++;
            @(negedge clk);
        end
        check_eq("start_with_rst/idle", 32'(nr), 32'd0);

        for (int t = 0; t < 9; t++) begin
            for (int s = 0; s < NUM_SYM; s++) begin
                case (t % 3)
                    0: mem[s] = ($urandom_range(15) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
                    1: mem[s] = 8'($urandom_range(3));
                    default: mem[s] = 8'($urandom_range(255));
                endcase
            end
            run_scan($sformatf("rand%0d", t), (t == 4) ? 120 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_min_finder.md
Name: freq_min_finder

Overview:
- Downstream consumer of the byte-frequency counter stage.
- Once counting finishes, scans the symbol-count table in SRAM and reports the two least-frequent non-zero symbols and the number of non-zero symbols.
- These results drive the next tree-build merge step.
- Shares the SRAM read port with the counter; owns it only while busy.

Parameters:
- NUM_SYM, 256, number of table entries scanned (symbol index = entry offset).
- ADDR_W, 10, SRAM address width.
- CNT_W, 8, width of one count entry.
- BASE_ADDR, 0, SRAM address of symbol 0's count.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- scan_start  in  1  one-cycle request to begin a scan.
- scan_addr  out  ADDR_W  SRAM read address.
- scan_r  out  1  SRAM read enable.
- scan_data  in  CNT_W  count returned by SRAM, valid the cycle after scan_r.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when results are valid.
- min1_sym  out  8  symbol with the smallest non-zero count.
- min1_cnt  out  CNT_W  its count.
- min2_sym  out  8  symbol with the second-smallest non-zero count.
- min2_cnt  out  CNT_W  its count.
- nz_count  out  9  number of symbols with count > 0 (0..256).
- err  out  1  fewer than two non-zero symbols found.

Behaviour:
- Reset: synchronous, active-high. Every output is 0, state is IDLE, and the valid flags are cleared. Reset mid-scan aborts immediately: scan_r drops on the next edge and no done pulse is produced.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: scan_start sampled high → SCAN. On that edge, clear min/nz registers and err, set the address index to 0, and set busy=1.
  - SCAN: scan_r=1 and scan_addr=BASE_ADDR+index. The index increments every cycle. After index NUM_SYM-1 is issued → DRAIN.
  - DRAIN: one cycle, scan_r=0; the last returned word is compared.
  - DONE: done=1 for one cycle, busy=0, err updated; then → IDLE.
- Timing: scan_r is high for exactly NUM_SYM consecutive cycles, starting the cycle after scan_start is sampled. done is high in cycle NUM_SYM+2 after the sampling edge (258 with defaults).
- Compare pipeline: a read-issued flag and symbol index are delayed by one cycle to pair with scan_data. Each returned word with count c at symbol s is processed as:
  - c==0: ignored.
  - otherwise nz_count += 1, then:
    - if !min1_v or c < min1_cnt: min2 ← min1 (including its valid flag), min1 ← (s,c).
    - else if !min2_v or c < min2_cnt: min2 ← (s,c).
  - Ties use strict less-than, so the lower symbol index wins.
- Outputs:
  - min*/nz_count update during the scan but are only guaranteed at done.
  - All results hold their values until the next accepted scan_start or rst.
  - err = (nz_count < 2), set at done and held. Fields with no valid entry stay 0.
- scan_start while busy (SCAN/DRAIN/DONE): ignored.
- scan_start on the same edge as rst: reset wins.
- Counts are unsigned; a count of 255 is legal. No saturation or overflow is possible in the comparisons.
- scan_addr holds its last value when not scanning. scan_r is never high outside SCAN.

Test Plan:
- Table with counts: sym 'A' (0x41)=5, 0x42=3, 0x43=9, all others 0. Pulse scan_start → scan_r high for exactly 256 cycles with addresses 0..255; done at cycle 258; min1=0x42/3, min2=0x41/5, nz_count=3, err=0.
- Tie case: 0x10=2, 0x20=2, 0x30=2 → min1=0x10/2, min2=0x20/2, nz_count=3 (lower index wins).
- Single non-zero entry 0x7F=1 → min1=0x7F/1, min2=0/0, nz_count=1, err=1. All-zero table → all results 0, nz_count=0, err=1.
- All 256 entries=255 except 0xFF=254 → min1=0xFF/254, min2=0x00/255, nz_count=256, err=0.
- Assert rst at cycle 100 of a scan → next cycle scan_r=0, busy=0, outputs 0, no done. A fresh scan_start then completes normally with correct results.
- Pulse scan_start again at cycle 50 of an active scan → ignored: address sequence uninterrupted, exactly one done, results identical to the single-scan case.
